tp84_sn_write_sched: RTL and testbench

- Write scheduler for the three SN76489 sound chips on the TP84 sound board.
- Accepts byte writes tagged with a target chip and buffers them in a small FIFO.
- Sequences each write through the shared data latch and the per-chip CE/WE/READY handshake, one chip at a time.
- Sits between the sound-CPU address decode (SN latch/enable strobes) and the sn76489_top instances; replaces the ad-hoc ready/CE gating.

---
 rtl/tp84_sn_write_sched.sv | 190 +++++++++++++++++++
 tb/tb_tp84_sn_write_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp84_sn_write_sched.sv
// tp84_sn_write_sched
//   Write scheduler for the three SN76489 chips on the TP84 sound board. Byte writes tagged
//   with a target chip are queued in a small FIFO and then sequenced, one at a time, through
//   the shared data latch and the per-chip CE/WE/READY handshake.
//
// Ports
//   clk_49m    system clock
//   reset      asynchronous active-high reset
//   wr_req     one-cycle write request
//   wr_chip    target chip (0=E5, 1=E6, 2=E7, 3 invalid)
//   wr_data    byte for the selected SN76489
//   fifo_full  FIFO holds DEPTH entries
//   busy       FIFO non-empty or sequencer not idle
//   sn_D       shared data bus to all chips
//   sn_ce_n    per-chip chip enable, active low
//   sn_we_n    per-chip write enable, active low
//   sn_ready   per-chip READY, high = idle
//   err_ovf    sticky: request dropped, FIFO full
//   err_chip   sticky: request with invalid chip dropped
//   err_tmo    sticky: READY did not return in time
//   err_clr    clears the sticky error flags
module tp84_sn_write_sched #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STROBE_MAX = 8,
    parameter int unsigned TIMEOUT    = 2048
) (
    input  logic       clk_49m,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [1:0] wr_chip,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       busy,
    output logic [7:0] sn_D,
    output logic [2:0] sn_ce_n,
    output logic [2:0] sn_we_n,
    input  logic [2:0] sn_ready,
    output logic       err_ovf,
    output logic       err_chip,
    output logic       err_tmo,
    input  logic       err_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = (STROBE_MAX > 1) ? $clog2(STROBE_MAX) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW:0]   FullCount  = (PW + 1)'(DEPTH);
    localparam logic [SW-1:0] StrobeLast = SW'(STROBE_MAX - 1);
    localparam logic [TW-1:0] TmoLast    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWaitRdy,
        StRelease
    } state_t;

    state_t state;

    // FIFO storage: {chip, data}
    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [9:0]    head;

    logic          chip_bad;
    logic          push;
    logic          pop;

    logic [1:0]    chip;
    logic [2:0]    chip_mask;
    logic          ready_sel;
    logic [SW-1:0] strb_cnt;
    logic [TW-1:0] tmo_cnt;

    assign fifo_full = (count == FullCount);
    assign busy      = (count != '0) || (state != StIdle);
    assign head      = mem[rd_ptr];

    assign chip_bad  = wr_req && (wr_chip == 2'd3);
    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign push      = wr_req && !chip_bad && !fifo_full;
    assign pop       = (state == StIdle) && (count != '0);

    assign chip_mask = 3'b001 << chip;
    assign ready_sel = |(sn_ready & chip_mask);

    // ------------------------------------------------------------------ FIFO
    always_ff @(posedge clk_49m) begin
        if (push) begin
            mem[wr_ptr] <= {wr_chip, wr_data};
        end
    end

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_ovf  <= 1'b0;
            err_chip <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // A new error in the same cycle as err_clr keeps the flag set.
            err_ovf  <= (wr_req && !chip_bad && fifo_full) || (err_ovf && !err_clr);
            err_chip <= chip_bad || (err_chip && !err_clr);
        end
    end

    // ------------------------------------------------------------------ sequencer
    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            sn_D     <= 8'h00;
            sn_ce_n  <= 3'b111;
            sn_we_n  <= 3'b111;
            chip     <= 2'd0;
            strb_cnt <= '0;
            tmo_cnt  <= '0;
            err_tmo  <= 1'b0;
        end else begin
            if (err_clr) begin
                err_tmo <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (count != '0) begin
                        sn_D  <= head[7:0];
                        chip  <= head[9:8];
                        state <= StSetup;
                    end
                end
                StSetup: begin
                    sn_ce_n  <= ~chip_mask;
                    sn_we_n  <= ~chip_mask;
                    strb_cnt <= '0;
                    state    <= StStrobe;
                end
                StStrobe: begin
                    if (!ready_sel) begin
                        tmo_cnt <= '0;
                        state   <= StWaitRdy;
                    end else if (strb_cnt == StrobeLast) begin
                        // Chip never signalled busy: treat the write as taken.
                        sn_ce_n <= 3'b111;
                        sn_we_n <= 3'b111;
                        state   <= StRelease;
                    end else begin
                        strb_cnt <= strb_cnt + 1'b1;
                    end
                end
                StWaitRdy: begin
                    if (ready_sel) begin
                        sn_ce_n <= 3'b111;
                        sn_we_n <= 3'b111;
                        state   <= StRelease;
                    end else if (tmo_cnt == TmoLast) begin
                        err_tmo <= 1'b1;
                        sn_ce_n <= 3'b111;
                        sn_we_n <= 3'b111;
                        state   <= StRelease;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StRelease: begin
                    // sn_D is left untouched for data hold.
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tp84_sn_write_sched.sv
module tb_tp84_sn_write_sched;

    localparam int DEPTH      = 4;
    localparam int STROBE_MAX = 8;
    localparam int TIMEOUT    = 2048;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       wr_req   = 1'b0;
    logic [1:0] wr_chip  = 2'd0;
    logic [7:0] wr_data  = 8'h00;
    logic [2:0] sn_ready = 3'b111;
    logic       err_clr  = 1'b0;

    logic       fifo_full;
    logic       busy;
    logic [7:0] sn_D;
    logic [2:0] sn_ce_n;
    logic [2:0] sn_we_n;
    logic       err_ovf;
    logic       err_chip;
    logic       err_tmo;

    tp84_sn_write_sched #(
        .DEPTH      (DEPTH),
        .STROBE_MAX (STROBE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_49m   (clk),
        .reset     (rst),
        .wr_req    (wr_req),
        .wr_chip   (wr_chip),
        .wr_data   (wr_data),
        .fifo_full (fifo_full),
        .busy      (busy),
        .sn_D      (sn_D),
        .sn_ce_n   (sn_ce_n),
        .sn_we_n   (sn_we_n),
        .sn_ready  (sn_ready),
        .err_ovf   (err_ovf),
        .err_chip  (err_chip),
        .err_tmo   (err_tmo),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: accepted writes not yet seen on the chip bus, in order.
    logic [9:0] exp_q[$];
    // READY of the strobed chip as the DUT will sample it, one entry per strobe cycle.
    bit   hist [0:4095];
    int   last_len = 0;
    int   nstrobe  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected number of cycles CE/WE stay low, derived from the READY history:
    // up to STROBE_MAX cycles waiting for READY to fall, then until READY rises or
    // TIMEOUT cycles elapse. Returns 0 if the history is too short to decide.
    function automatic int exp_len(input int n, output bit tmo);
        int k;
        tmo = 1'b0;
        k   = -1;
        for (int i = 0; i < STROBE_MAX; i++) begin
            if (i >= n) return 0;
            if (hist[i] == 1'b0) begin
                k = i;
                break;
            end
        end
        if (k < 0) return STROBE_MAX;
        for (int j = 1; j <= TIMEOUT; j++) begin
            if (k + j >= n) return 0;
            if (hist[k + j] == 1'b1) return k + j + 1;
        end
        tmo = 1'b1;
        return k + 1 + TIMEOUT;
    endfunction

    // ---------------------------------------------------------------- compare process
    bit         in_strb   = 1'b0;
    bit         idle_next = 1'b0;
    logic [9:0] cur       = '0;
    int         len       = 0;
    logic [7:0] prev_d    = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            in_strb   = 1'b0;
            idle_next = 1'b0;
            check("reset_ce", 32'(sn_ce_n), 32'h7);
        end else begin
            logic [2:0] low;
            low = ~sn_ce_n;
            check("ce_eq_we", 32'(sn_ce_n), 32'(sn_we_n));
            check("onehot_ce", 32'($countones(low) <= 1), 32'd1);
            if (!in_strb) begin
                if (low != 3'b000) begin
                    check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    check("strobe_chip", 32'(low), 32'(3'b001 << cur[9:8]));
                    check("strobe_data", 32'(sn_D), 32'(cur[7:0]));
                    check("setup_data", 32'(prev_d), 32'(cur[7:0]));
                    check("strobe_busy", 32'(busy), 32'd1);
                    check("strobe_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
                    in_strb   = 1'b1;
                    idle_next = 1'b0;
                    hist[0]   = sn_ready[cur[9:8]];
                    len       = 1;
                end else if (idle_next) begin
                    check("idle_busy", 32'(busy), 32'(exp_q.size() != 0));
                    idle_next = 1'b0;
                end
            end else if (low != 3'b000) begin
                check("hold_chip", 32'(low), 32'(3'b001 << cur[9:8]));
                check("hold_data", 32'(sn_D), 32'(cur[7:0]));
                check("hold_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
                if (len < 4096) hist[len] = sn_ready[cur[9:8]];
                len++;
            end else begin
                bit tmo;
                int e;
                e = exp_len(len, tmo);
                check("strobe_len", 32'(len), 32'(e));
                if (tmo) check("tmo_flag", 32'(err_tmo), 32'd1);
                check("release_data", 32'(sn_D), 32'(cur[7:0]));
                check("release_busy", 32'(busy), 32'd1);
                last_len  = len;
                nstrobe++;
                in_strb   = 1'b0;
                idle_next = 1'b1;
            end
            prev_d = sn_D;
        end
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic push(input logic [1:0] c, input logic [7:0] d, input bit acc);
        wr_req  = 1'b1;
        wr_chip = c;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        if (acc) exp_q.push_back({c, d});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic wait_strobe(input int c, input int limit);
        int n = 0;
        while (sn_ce_n[c] !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        check("wait_strobe", 32'(sn_ce_n[c]), 32'd0);
    endtask

    task automatic wait_release(input int limit);
        int n = 0;
        while (sn_ce_n !== 3'b111 && n < limit) begin
            tick(1);
            n++;
        end
        check("wait_release", 32'(sn_ce_n), 32'h7);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- directed tests
    initial begin
        int n0;

        // Reset values
        tick(1);
        check("rst_ce", 32'(sn_ce_n), 32'h7);
        check("rst_we", 32'(sn_we_n), 32'h7);
        check("rst_d", 32'(sn_D), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_errs", 32'({err_ovf, err_chip, err_tmo}), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Single write to chip 1; READY low 2 cycles into the strobe, high 32 later
        push(2'd1, 8'h9F, 1'b1);
        wait_strobe(1, 20);
        check("t1_ce", 32'(sn_ce_n), 32'h5);
        check("t1_we", 32'(sn_we_n), 32'h5);
        check("t1_d", 32'(sn_D), 32'h9F);
        tick(2);
        sn_ready[1] = 1'b0;
        tick(32);
        sn_ready[1] = 1'b1;
        check("t1_ce_still_low", 32'(sn_ce_n), 32'h5);
        tick(1);
        check("t1_ce_released", 32'(sn_ce_n), 32'h7);
        check("t1_we_released", 32'(sn_we_n), 32'h7);
        check("t1_release_busy", 32'(busy), 32'd1);
        check("t1_hold_d", 32'(sn_D), 32'h9F);
        tick(1);
        check("t1_busy_drop", 32'(busy), 32'd0);
        check("t1_len", 32'(last_len), 32'd35);

        // Invalid chip: dropped and flagged; set wins over same-cycle clear
        push(2'd3, 8'h12, 1'b0);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_full", 32'(fifo_full), 32'd0);
        check("t2_err_chip", 32'(err_chip), 32'd1);
        check("t2_err_ovf", 32'(err_ovf), 32'd0);
        err_clr = 1'b1;
        push(2'd3, 8'h34, 1'b0);
        err_clr = 1'b0;
        check("t2_set_over_clr", 32'(err_chip), 32'd1);
        clr_pulse();
        check("t2_cleared", 32'(err_chip), 32'd0);
        tick(2);
        check("t2_no_strobe", 32'(sn_ce_n), 32'h7);

        // READY never falls: strobe lasts STROBE_MAX cycles, no timeout
        push(2'd2, 8'h5A, 1'b1);
        wait_idle(40);
        check("t3_len", 32'(last_len), 32'd8);
        check("t3_no_tmo", 32'(err_tmo), 32'd0);

        // Fill the FIFO while chip 0 holds the sequencer in WAIT_RDY
        n0 = nstrobe;
        push(2'd0, 8'h11, 1'b1);
        wait_strobe(0, 20);
        sn_ready[0] = 1'b0;
        push(2'd0, 8'h80, 1'b1);
        push(2'd2, 8'hA0, 1'b1);
        push(2'd1, 8'hC0, 1'b1);
        check("t4_not_full_3", 32'(fifo_full), 32'd0);
        push(2'd0, 8'hE0, 1'b1);
        check("t4_full", 32'(fifo_full), 32'd1);
        check("t4_no_ovf_yet", 32'(err_ovf), 32'd0);
        push(2'd1, 8'hFF, 1'b0);
        check("t4_ovf", 32'(err_ovf), 32'd1);
        check("t4_still_full", 32'(fifo_full), 32'd1);
        tick(3);
        sn_ready[0] = 1'b1;
        wait_idle(300);
        check("t4_count", 32'(nstrobe - n0), 32'd5);
        check("t4_last_d", 32'(sn_D), 32'hE0);
        clr_pulse();
        check("t4_ovf_cleared", 32'(err_ovf), 32'd0);

        // READY falls and never rises: timeout, then the next entry is serviced
        n0 = nstrobe;
        push(2'd2, 8'h33, 1'b1);
        push(2'd1, 8'h44, 1'b1);
        wait_strobe(2, 20);
        sn_ready[2] = 1'b0;
        wait_release(2200);
        check("t5_err_tmo", 32'(err_tmo), 32'd1);
        tick(1);
        check("t5_len", 32'(last_len), 32'd2049);
        sn_ready[2] = 1'b1;
        wait_idle(60);
        check("t5_count", 32'(nstrobe - n0), 32'd2);
        check("t5_last_d", 32'(sn_D), 32'h44);
        clr_pulse();
        check("t5_tmo_cleared", 32'(err_tmo), 32'd0);

        // Reset during WAIT_RDY with two entries queued
        push(2'd0, 8'h55, 1'b1);
        wait_strobe(0, 20);
        sn_ready[0] = 1'b0;
        push(2'd1, 8'h66, 1'b1);
        push(2'd2, 8'h77, 1'b1);
        tick(2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_ce_async", 32'(sn_ce_n), 32'h7);
        check("t6_we_async", 32'(sn_we_n), 32'h7);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_full", 32'(fifo_full), 32'd0);
        check("t6_d", 32'(sn_D), 32'h00);
        tick(2);
        rst = 1'b0;
        sn_ready[0] = 1'b1;
        tick(2);
        check("t6_idle_after", 32'(busy), 32'd0);
        n0 = nstrobe;
        push(2'd1, 8'hC3, 1'b1);
        wait_idle(40);
        check("t6_count", 32'(nstrobe - n0), 32'd1);
        check("t6_d_after", 32'(sn_D), 32'hC3);
        check("t6_len", 32'(last_len), 32'd8);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
